// File: rtl/mux_pkg.sv
// Shared types and widths for the 4:1 mux serializer.
package mux_pkg;

  localparam int unsigned WORD_W = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/four_mx.sv
// Plain 4:1 bit multiplexer used as the serializer output select.
module four_mx (
  input  logic [3:0] i,
  input  logic [1:0] sel,
  output logic       f
);

  // Select one of four inputs.
  always_comb begin
    f = 1'b0;
    case (sel)
      2'd0:    f = i[0];
      2'd1:    f = i[1];
      2'd2:    f = i[2];
      default: f = i[3];
    endcase
  end

endmodule

// File: rtl/mux_serializer.sv
// 4-bit parallel-to-serial converter with valid/ready on both sides.
// A new word may be accepted on the last beat of the previous one, so
// words stream with no gap while out_ready stays high.
module mux_serializer
  import mux_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam logic [SEL_W-1:0] FIRST_SEL = LSB_FIRST ? SEL_W'(0) : SEL_W'(WORD_W - 1);
  localparam logic [SEL_W-1:0] LAST_SEL  = LSB_FIRST ? SEL_W'(WORD_W - 1) : SEL_W'(0);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mux_f;
  logic                beat;
  logic                accept;

  // Bit select from the held word.
  four_mx u_mx (
    .i   (hold_q),
    .sel (sel_q),
    .f   (mux_f)
  );

  // State and datapath registers; reset wins over any accept or beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake decode, next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    out_valid = (state_q == SHIFT);
    out_last  = out_valid & (sel_q == LAST_SEL);
    in_ready  = (state_q == IDLE) | ((state_q == SHIFT) & out_last & out_ready);
    beat      = out_valid & out_ready;
    accept    = in_valid & in_ready;

    case (state_q)
      IDLE: begin
        if (accept) begin
          hold_d  = in_data;
          sel_d   = FIRST_SEL;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (out_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (in_valid) begin
              hold_d = in_data;
              sel_d  = FIRST_SEL;
            end else begin
              state_d = IDLE;
            end
          end else if (LSB_FIRST) begin
            sel_d = sel_q + SEL_W'(1);
          end else begin
            sel_d = sel_q - SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output bit is forced low whenever no word is being shifted.
  assign out_bit  = out_valid & mux_f;
  assign sel      = sel_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_mux_serializer.sv
// Self-checking bench: an LSB-first and an MSB-first instance share the
// same stimulus and are compared every cycle against a beat-counting model.
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'd0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_l, out_bit_l, out_valid_l, out_last_l;
  logic [1:0] sel_l;
  logic [7:0] word_cnt_l;
  logic       in_ready_m, out_bit_m, out_valid_m, out_last_m;
  logic [1:0] sel_m;
  logic [7:0] word_cnt_m;

  int errors = 0;
  int checks = 0;

  // model: busy flag, held word, beats already taken, word count
  bit         m_busy = 1'b0;
  logic [3:0] m_word = 4'd0;
  int         m_k = 0;
  int         m_cnt = 0;
  bit         m_sel0 = 1'b1;

  // observed values from the last sampled cycle (index 0 = LSB dut, 1 = MSB dut)
  logic       o_valid [2];
  logic       o_bit   [2];
  logic       o_last  [2];
  logic       o_ready [2];
  logic [1:0] o_sel   [2];
  logic [7:0] o_cnt   [2];

  always #5 clk = ~clk;

  mux_serializer #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_l), .out_bit(out_bit_l), .out_valid(out_valid_l),
    .out_ready(out_ready), .out_last(out_last_l), .sel(sel_l), .word_cnt(word_cnt_l)
  );

  mux_serializer #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .out_bit(out_bit_m), .out_valid(out_valid_m),
    .out_ready(out_ready), .out_last(out_last_m), .sel(sel_m), .word_cnt(word_cnt_m)
  );

  // One clock: drive, sample and compare against the model, then advance the model.
  task automatic run_cycle(input bit r, input bit v, input logic [3:0] d, input bit ordy);
    logic       e_last, e_ready;
    logic [1:0] e_sel [2];
    logic       e_bit [2];
    @(negedge clk);
    rst = r; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    o_valid[0] = out_valid_l; o_bit[0] = out_bit_l; o_last[0] = out_last_l;
    o_ready[0] = in_ready_l;  o_sel[0] = sel_l;     o_cnt[0]  = word_cnt_l;
    o_valid[1] = out_valid_m; o_bit[1] = out_bit_m; o_last[1] = out_last_m;
    o_ready[1] = in_ready_m;  o_sel[1] = sel_m;     o_cnt[1]  = word_cnt_m;
    e_last   = m_busy && (m_k == 3);
    e_ready  = !m_busy || (e_last && ordy);
    e_sel[0] = m_busy ? 2'(m_k) : 2'd0;
    e_sel[1] = m_busy ? 2'(3 - m_k) : 2'd0;
    e_bit[0] = m_busy ? m_word[e_sel[0]] : 1'b0;
    e_bit[1] = m_busy ? m_word[e_sel[1]] : 1'b0;
    for (int j = 0; j < 2; j++) begin
      checks += 5;
      if (o_valid[j] !== m_busy) begin
        errors++; $display("FAIL out_valid dut%0d t=%0t got=%b exp=%b", j, $time, o_valid[j], m_busy);
      end
      if (o_last[j] !== e_last) begin
        errors++; $display("FAIL out_last dut%0d t=%0t got=%b exp=%b", j, $time, o_last[j], e_last);
      end
      if (o_ready[j] !== e_ready) begin
        errors++; $display("FAIL in_ready dut%0d t=%0t got=%b exp=%b", j, $time, o_ready[j], e_ready);
      end
      if (o_bit[j] !== e_bit[j]) begin
        errors++; $display("FAIL out_bit dut%0d t=%0t got=%b exp=%b", j, $time, o_bit[j], e_bit[j]);
      end
      if (o_cnt[j] !== 8'(m_cnt)) begin
        errors++; $display("FAIL word_cnt dut%0d t=%0t got=%0d exp=%0d", j, $time, o_cnt[j], m_cnt);
      end
      if (m_busy || m_sel0) begin
        checks++;
        if (o_sel[j] !== e_sel[j]) begin
          errors++; $display("FAIL sel dut%0d t=%0t got=%0d exp=%0d", j, $time, o_sel[j], e_sel[j]);
        end
      end
    end
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_word = 4'd0; m_k = 0; m_cnt = 0; m_sel0 = 1'b1;
    end else if (m_busy) begin
      if (ordy) begin
        if (m_k == 3) begin
          m_cnt = (m_cnt + 1) % 256;
          if (v) begin m_word = d; m_k = 0; end
          else m_busy = 1'b0;
        end else begin
          m_k++;
        end
      end
    end else if (v) begin
      m_busy = 1'b1; m_word = d; m_k = 0; m_sel0 = 1'b0;
    end
  endtask

  task automatic test_reset();
    run_cycle(1'b1, 1'b1, 4'hF, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b0);
    checks++;
    if (o_ready[0] !== 1'b1 || o_valid[0] !== 1'b0 || o_bit[0] !== 1'b0 ||
        o_last[0] !== 1'b0 || o_cnt[0] !== 8'd0 || o_sel[0] !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b bit=%b last=%b cnt=%0d sel=%0d exp 1 0 0 0 0 0",
               o_ready[0], o_valid[0], o_bit[0], o_last[0], o_cnt[0], o_sel[0]);
    end
  endtask

  task automatic test_lsb_first();
    logic exp_bit [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    run_cycle(1'b0, 1'b1, 4'b1010, 1'b1);
    for (int b = 0; b < 4; b++) begin
      run_cycle(1'b0, 1'b0, 4'($urandom), 1'b1);
      checks++;
      if (o_sel[0] !== 2'(b) || o_bit[0] !== exp_bit[b] || o_last[0] !== (b == 3)) begin
        errors++;
        $display("FAIL lsb_seq beat%0d got sel=%0d bit=%b last=%b exp sel=%0d bit=%b last=%b",
                 b, o_sel[0], o_bit[0], o_last[0], b, exp_bit[b], (b == 3));
      end
    end
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    checks++;
    if (o_cnt[0] !== 8'd1 || o_valid[0] !== 1'b0) begin
      errors++; $display("FAIL lsb_done got cnt=%0d vld=%b exp cnt=1 vld=0", o_cnt[0], o_valid[0]);
    end
  endtask

  task automatic test_msb_first();
    logic exp_bit [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_cycle(1'b0, 1'b1, 4'b1100, 1'b1);
    for (int b = 0; b < 4; b++) begin
      run_cycle(1'b0, 1'b0, 4'($urandom), 1'b1);
      checks++;
      if (o_sel[1] !== 2'(3 - b) || o_bit[1] !== exp_bit[b] || o_last[1] !== (b == 3)) begin
        errors++;
        $display("FAIL msb_seq beat%0d got sel=%0d bit=%b last=%b exp sel=%0d bit=%b last=%b",
                 b, o_sel[1], o_bit[1], o_last[1], 3 - b, exp_bit[b], (b == 3));
      end
    end
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    run_cycle(1'b1, 1'b0, 4'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 4'b1010, 1'b1);
    for (int c = 0; c < 8; c++) begin
      // junk on in_data during the first word must be ignored
      run_cycle(1'b0, c < 4, (c == 3) ? 4'b1100 : 4'($urandom), 1'b1);
      if (o_valid[0] === 1'b1) nvalid++;
      if (c == 3) begin
        checks++;
        if (o_ready[0] !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_on_last got=%b exp=1", o_ready[0]);
        end
      end
    end
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    checks++;
    if (nvalid != 8 || o_cnt[0] !== 8'd2 || o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_summary got valid_cycles=%0d cnt=%0d vld=%b exp 8 2 0", nvalid, o_cnt[0], o_valid[0]);
    end
  endtask

  task automatic test_stall();
    run_cycle(1'b0, 1'b1, 4'b1010, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    for (int s = 0; s < 4; s++) begin
      run_cycle(1'b0, 1'b1, 4'($urandom), s == 3);
      checks++;
      if (o_sel[0] !== 2'd1 || o_bit[0] !== 1'b1 || o_valid[0] !== 1'b1 || o_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got sel=%0d bit=%b vld=%b rdy=%b exp 1 1 1 0",
                 s, o_sel[0], o_bit[0], o_valid[0], o_ready[0]);
      end
    end
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
  endtask

  task automatic test_reset_mid();
    run_cycle(1'b1, 1'b0, 4'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 4'b1010, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    run_cycle(1'b1, 1'b1, 4'hF, 1'b1);
    checks++;
    if (o_sel[0] !== 2'd2) begin
      errors++; $display("FAIL mid_reset_at_sel got=%0d exp=2", o_sel[0]);
    end
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    checks++;
    if (o_valid[0] !== 1'b0 || o_cnt[0] !== 8'd0 || o_ready[0] !== 1'b1 || o_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got vld=%b cnt=%0d rdy=%b exp 0 0 1", o_valid[0], o_cnt[0], o_ready[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++)
      run_cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                4'($urandom), ($urandom_range(0, 3) != 0));
  endtask

  task automatic test_wrap();
    run_cycle(1'b1, 1'b0, 4'h0, 1'b0);
    run_cycle(1'b0, 1'b1, 4'($urandom), 1'b1);
    for (int c = 0; c < 256 * 4; c++)
      run_cycle(1'b0, c < 255 * 4, 4'($urandom), 1'b1);
    run_cycle(1'b0, 1'b0, 4'h0, 1'b1);
    checks++;
    if (o_cnt[0] !== 8'd0 || o_cnt[1] !== 8'd0 || o_valid[0] !== 1'b0) begin
      errors++; $display("FAIL wrap got cnt=%0d/%0d vld=%b exp 0/0 0", o_cnt[0], o_cnt[1], o_valid[0]);
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
